// File: rtl/sm_icache.sv
// Direct-mapped instruction cache. Hits are answered combinationally. A miss
// refills the whole line from instruction memory, one word per mem_valid, in ascending order.
module sm_icache #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4,
  parameter int OFF_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_valid
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << (INDEX_W + OFF_W);
  localparam logic [OFF_W-1:0] CNT_LAST = '1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_REFILL = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [TAG_W-1:0]   r_tag_q, r_tag_d;
  logic [INDEX_W-1:0] r_idx_q, r_idx_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]   valid_q, valid_d;

  logic [31:0]      data_q [WORDS];
  logic [TAG_W-1:0] tag_q  [LINES];

  logic [OFF_W-1:0]   off;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               refill_wr;
  logic               refill_done;

  assign off = cpu_addr[OFF_W-1:0];
  assign idx = cpu_addr[OFF_W+INDEX_W-1:OFF_W];
  assign tag = cpu_addr[ADDR_W-1:OFF_W+INDEX_W];

  assign hit         = valid_q[idx] && (tag_q[idx] == tag);
  assign refill_wr   = (state_q == S_REFILL) && mem_valid;
  assign refill_done = refill_wr && (cnt_q == CNT_LAST);

  // A flush in the same cycle as a request suppresses the hit.
  assign cpu_ready = (state_q == S_IDLE) && cpu_req && !flush && hit;
  assign cpu_rdata = data_q[{idx, off}];

  assign mem_req  = (state_q == S_REFILL);
  assign mem_addr = mem_req ? {r_tag_q, r_idx_q, cnt_q} : '0;

  always_comb begin
    // NOTE: every _d is first defaulted to its _q so no path through this block can infer a latch.
    state_d = state_q;
    r_tag_d = r_tag_q;
    r_idx_d = r_idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;

    if (state_q == S_IDLE) begin
      if (flush) begin
        valid_d = '0;
      end else if (cpu_req && !hit) begin
        r_tag_d      = tag;
        r_idx_d      = idx;
        valid_d[idx] = 1'b0;
        cnt_d        = '0;
        state_d      = S_REFILL;
      end
    end else if (mem_valid) begin
      cnt_d = cnt_q + OFF_W'(1);
      if (cnt_q == CNT_LAST) begin
        valid_d[r_idx_q] = 1'b1;
        state_d          = S_IDLE;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_tag_q <= '0;
      r_idx_q <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      r_tag_q <= r_tag_d;
      r_idx_q <= r_idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: the data and tag arrays are left out of reset; valid_q alone decides whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (refill_wr) begin
      data_q[{r_idx_q, cnt_q}] <= mem_rdata;
    end
    if (refill_done) begin
      tag_q[r_idx_q] <= r_tag_q;
    end
  end
endmodule

// File: tb/tb_sm_icache.sv
// Bench for sm_icache: directed scenarios plus random fetches, checked against
// a line-level model of which memory line each cache set holds.
module tb_sm_icache;
  localparam int ADDR_W     = 32;
  localparam int INDEX_W    = 4;
  localparam int OFF_W      = 2;
  localparam int LINES      = 1 << INDEX_W;
  localparam int LINE_WORDS = 1 << OFF_W;
  localparam int TIMEOUT    = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_valid;

  int checks   = 0;
  int failures = 0;

  // Memory responder: mem_valid after wait_n idle cycles per word; stray_valid injects mem_valid with no request.
  int   wait_n      = 0;
  int   wcnt        = 0;
  logic stray_valid = 1'b0;

  // Reference model: the memory line number each set currently holds.
  bit          m_valid [LINES];
  logic [31:0] m_line  [LINES];

  logic [31:0] exp_seq[$];
  logic [31:0] obs_seq[$];
  int          exp_cyc;
  int          obs_cyc;
  logic [31:0] exp_data;
  logic [31:0] obs_data;

  always #5 clk = ~clk;

  sm_icache #(
    .ADDR_W (ADDR_W),
    .INDEX_W(INDEX_W),
    .OFF_W  (OFF_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .flush    (flush),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  assign mem_rdata = mem_word(mem_addr);
  assign mem_valid = (mem_req && (wcnt == wait_n)) || stray_valid;

  always @(posedge clk) begin
    wcnt <= (mem_req && !mem_valid) ? wcnt + 1 : 0;
  end

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  // Expected latency, data and memory-address trace for a fetch; updates the model.
  function automatic void predict(input logic [31:0] a);
    logic [31:0] line;
    int          set;
    line = a >> OFF_W;
    set  = int'(line[INDEX_W-1:0]);
    exp_seq.delete();
    exp_data = mem_word(a);
    if (m_valid[set] && m_line[set] == line) begin
      exp_cyc = 0;
    end else begin
      exp_cyc = 1 + LINE_WORDS * (wait_n + 1);
      for (int k = 0; k < LINE_WORDS; k++)
        for (int r = 0; r <= wait_n; r++)
          exp_seq.push_back((line << OFF_W) + 32'(k));
      m_valid[set] = 1'b1;
      m_line[set]  = line;
    end
  endfunction

  function automatic int seq_diff();
    int n;
    n = (obs_seq.size() < exp_seq.size()) ? obs_seq.size() : exp_seq.size();
    for (int i = 0; i < n; i++)
      if (obs_seq[i] !== exp_seq[i]) return i;
    if (obs_seq.size() != exp_seq.size()) return n;
    return -1;
  endfunction

  // Starts at a falling edge, holds the request until cpu_ready, returns at a falling edge.
  task automatic fetch(input logic [31:0] a);
    obs_seq.delete();
    obs_cyc  = 0;
    obs_data = 'x;
    cpu_req  = 1'b1;
    cpu_addr = a;
    #1;
    while (!cpu_ready && obs_cyc < TIMEOUT) begin
      if (mem_req) obs_seq.push_back(mem_addr);
      @(negedge clk);
      #1;
      obs_cyc++;
    end
    if (cpu_ready) obs_data = cpu_rdata;
    else obs_cyc = -1;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    flush    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem_req: got %b expected 0", mem_req);
    end
    checks++;
    if (mem_addr !== '0) begin
      failures++;
      $display("FAIL reset_mem_addr: got %h expected 0", mem_addr);
    end
    cpu_req  = 1'b1;
    cpu_addr = 32'h5;
    #1;
    checks++;
    if (cpu_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_hit: got cpu_ready=%b expected 0", cpu_ready);
    end
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed(input string name, input logic [31:0] addrs[$], input int waits);
    wait_n = waits;
    foreach (addrs[i]) begin
      predict(addrs[i]);
      fetch(addrs[i]);
      checks++;
      if (obs_cyc !== exp_cyc) begin
        failures++;
        $display("FAIL %s_latency addr=%h: got %0d cycles expected %0d", name, addrs[i], obs_cyc, exp_cyc);
      end
      checks++;
      if (obs_data !== exp_data) begin
        failures++;
        $display("FAIL %s_rdata addr=%h: got %h expected %h", name, addrs[i], obs_data, exp_data);
      end
      checks++;
      if (seq_diff() != -1) begin
        failures++;
        $display("FAIL %s_mem_addr_seq addr=%h: got %0d beats expected %0d, first difference at %0d",
                 name, addrs[i], obs_seq.size(), exp_seq.size(), seq_diff());
      end
    end
    wait_n = 0;
  endtask

  task automatic test_reset_mid_refill();
    cpu_req  = 1'b1;
    cpu_addr = 32'h2A1;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h2A0) begin
      failures++;
      $display("FAIL midreset_first_word: got req=%b addr=%h expected req=1 addr=000002a0", mem_req, mem_addr);
    end
    @(negedge clk);
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== '0) begin
      failures++;
      $display("FAIL midreset_idle: got req=%b addr=%h expected req=0 addr=0", mem_req, mem_addr);
    end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_flush();
    flush    = 1'b1;
    cpu_req  = 1'b1;
    cpu_addr = 32'h5;
    #1;
    checks++;
    if (cpu_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_suppresses_hit: got cpu_ready=%b expected 0", cpu_ready);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_refill: got mem_req=%b expected 0", mem_req);
    end
    model_clear();
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_stray_valid();
    stray_valid = 1'b1;
    cpu_req     = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b0) begin
        failures++;
        $display("FAIL stray_valid_mem_req: got %b expected 0", mem_req);
      end
    end
    stray_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
      end else begin
        wait_n = $urandom_range(0, 2);
        a      = $urandom_range(0, 255);
        predict(a);
        fetch(a);
        checks++;
        if (obs_cyc !== exp_cyc || obs_data !== exp_data) begin
          failures++;
          $display("FAIL random_fetch addr=%h: got %0d cycles data %h expected %0d cycles data %h",
                   a, obs_cyc, obs_data, exp_cyc, exp_data);
        end
        checks++;
        if (seq_diff() != -1) begin
          failures++;
          $display("FAIL random_mem_addr_seq addr=%h: got %0d beats expected %0d, first difference at %0d",
                   a, obs_seq.size(), exp_seq.size(), seq_diff());
        end
      end
    end
    wait_n = 0;
  endtask

  initial begin
    test_reset();
    test_directed("cold_miss", '{32'h05}, 0);
    test_directed("same_line_hits", '{32'h06, 32'h04}, 0);
    test_directed("conflict", '{32'h45, 32'h05}, 0);
    test_directed("wait_states", '{32'h123}, 2);
    test_reset_mid_refill();
    test_directed("refetch_after_reset", '{32'h2A1, 32'h05}, 0);
    test_directed("pre_flush_hit", '{32'h05}, 0);
    test_flush();
    test_directed("post_flush_miss", '{32'h05}, 0);
    test_stray_valid();
    test_directed("post_stray_hit", '{32'h05}, 0);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sm_icache.md
# sm_icache

Direct-mapped instruction cache placed between the CPU fetch port and the instruction memory. On a hit it returns the instruction word combinationally, in the same cycle. On a miss it acts as the read initiator towards the backing instruction memory and fetches a whole line word by word through a req/valid handshake. Once the line is stored, it answers the CPU.

## Interface

**Parameters**
- `ADDR_W`, 32: width of the word address on both sides.
- `INDEX_W`, 4: index bits; the cache has 2^INDEX_W lines.
- `OFF_W`, 2: word-offset bits; each line holds 2^OFF_W 32-bit words.
- The tag width is derived as `TAG_W = ADDR_W - INDEX_W - OFF_W`.

**Ports**
- Clock and reset:
  - `clk`, in, 1: the single clock. All state changes on its rising edge.
  - `rst`, in, 1: synchronous, active-high reset.
- CPU side:
  - `cpu_req`, in, 1: fetch request. Must be held high until `cpu_ready`.
  - `cpu_addr`, in, ADDR_W: word address. Must be held stable while `cpu_req` is high and `cpu_ready` is low.
  - `cpu_rdata`, out, 32: instruction word. Valid only when `cpu_ready` is high.
  - `cpu_ready`, out, 1: high for the cycle in which `cpu_rdata` is valid.
- Control:
  - `flush`, in, 1: invalidates all lines. Sampled only in IDLE.
- Memory side:
  - `mem_req`, out, 1: read request.
  - `mem_addr`, out, ADDR_W: word address of the requested word.
  - `mem_rdata`, in, 32: read data. Valid when `mem_valid` is high.
  - `mem_valid`, in, 1: read data valid. Counts only while `mem_req` is high; may be asserted in the same cycle as `mem_req` (zero-wait memory).

## Operation

**Address split**
- `off = cpu_addr[OFF_W-1:0]`
- `idx = cpu_addr[OFF_W+INDEX_W-1:OFF_W]`
- `tag = cpu_addr[ADDR_W-1:OFF_W+INDEX_W]`

**Storage**
- Data array: 2^(INDEX_W+OFF_W) words, not reset.
- Tag array: 2^INDEX_W entries, not reset.
- Valid vector: 2^INDEX_W bits, cleared by reset.

**Hit detection**
- `hit = valid[idx] && tag_arr[idx] == tag`.

**FSM: two states, IDLE and REFILL. Reset state is IDLE.**

IDLE
- `cpu_req && hit` (and no flush): `cpu_ready = 1` and `cpu_rdata = data[idx][off]`, both combinational. The state stays IDLE.
- `cpu_req && !hit` (and no flush):
  - latch `r_tag = tag` and `r_idx = idx`;
  - clear `valid[idx]`;
  - reset word counter `cnt` to 0;
  - go to REFILL.
- `flush`: clear all valid bits; force `cpu_ready = 0` this cycle; take no miss action. The state stays IDLE.
- `cpu_req` low: no action.

REFILL
- `mem_req = 1` and `mem_addr = {r_tag, r_idx, cnt}`.
- Each cycle with `mem_valid`:
  - write `mem_rdata` to `data[r_idx][cnt]`;
  - increment `cnt`.
- When `cnt == 2^OFF_W - 1` and `mem_valid`:
  - write `tag_arr[r_idx] = r_tag`;
  - set `valid[r_idx]`;
  - go to IDLE.
- `cpu_ready = 0` throughout REFILL.
- `flush` is ignored in REFILL.

**Outputs and other rules**
- `mem_req` and `mem_addr` are registered-state decodes: they depend only on the state and the registers, never combinationally on `mem_valid`.
- Words are fetched strictly in ascending offset order, starting at offset 0. There is no critical-word-first.
- `cpu_rdata` is don't-care when `cpu_ready = 0`.

## Timing

**Reset values**
- state IDLE, all valid bits 0, `cnt` 0.
- `mem_req = 0`, `mem_addr = 0`, `cpu_ready = 0`.

**Latency**
- Hit: 0 cycles; `cpu_ready` is high in the request cycle.
- Miss with zero-wait memory:
  - cycle 0: miss detected;
  - cycles 1 to 2^OFF_W: REFILL;
  - cycle 2^OFF_W + 1: IDLE hit, `cpu_ready` high.
  - With `OFF_W = 2`, `cpu_ready` rises 5 cycles after the request.
- Each memory wait cycle adds one cycle. During wait cycles `mem_req` and `mem_addr` hold steady.

**Boundary conditions**
- A miss that evicts a valid line clears that line's valid bit at miss detection. The evicted line is never a hit during REFILL.
- `cnt` wraps from 2^OFF_W - 1 to 0, coinciding with the exit from REFILL.
- `rst` asserted mid-REFILL:
  - the state is IDLE and `mem_req` is 0 in the next cycle;
  - all valid bits are cleared;
  - a partially written line is never valid.
- `flush` and `cpu_req` asserted together in IDLE: flush wins, no hit is reported, no refill starts. The request is served from the next cycle onward as a miss.
- `mem_valid` while `mem_req = 0` is ignored.

## Test plan

1. **Reset, then cold miss.** After reset, request `cpu_addr = 0x05`; memory is zero-wait with `mem[a] = 0x1000_0000 + a`.
   - `mem_addr` sequence is 0x04, 0x05, 0x06, 0x07 in cycles 1–4.
   - `cpu_ready` is high in cycle 5 with `cpu_rdata = 0x1000_0005`.
2. **Same-line hits.** Following scenario 1, request 0x06, then 0x04.
   - `cpu_ready` is high in the same cycle as each request, with `cpu_rdata` 0x1000_0006, then 0x1000_0004.
   - `mem_req` stays 0.
3. **Conflict eviction.** Request 0x45 (index 1, new tag).
   - Refill reads 0x44 through 0x47; `cpu_rdata = 0x1000_0045`.
   - A following request to 0x05 misses again and refills 0x04 through 0x07.
4. **Wait-state memory.** `mem_valid` asserted every third cycle during a miss.
   - `mem_addr` holds each word address for 3 cycles.
   - `cpu_ready` rises exactly 1 + 4×3 cycles after the request.
5. **Reset mid-refill.** Assert `rst` after 2 words of a refill.
   - Next cycle: `mem_req = 0` and the state is IDLE.
   - Re-requesting the same address misses and refills from offset 0.
6. **Flush.** After scenario 2, pulse `flush` together with `cpu_req` at 0x05.
   - `cpu_ready = 0` in that cycle.
   - The next cycle misses and issues `mem_addr = 0x04` first.
